// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: one-at-a-time request/response wrapper around the fpu with stale-finish masking.
// Define FPU_TIMEOUT_EN to abandon multi-cycle ops that never finish (qNaN + rsp_err).
module fpu_issue_ctrl #(
    parameter int MIN_WAIT = 2,
    parameter int TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_funct,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [3:0]  fpu_funct,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    input  logic [31:0] fpu_o,
    input  logic        fpu_finish,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        busy
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    fpu_funct_q, fpu_funct_d;
    logic [31:0]   fpu_a_q, fpu_a_d, fpu_b_q, fpu_b_d, rsp_data_q, rsp_data_d;
    logic          rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic          done;

    function automatic logic is_multi(input logic [3:0] f);
        return f == 4'd0 || f == 4'd1 || f == 4'd3;
    endfunction

    function automatic logic is_supported(input logic [3:0] f);
        return is_multi(f) || f == 4'd4 || f == 4'd5;
    endfunction

    // finish is only trusted after MIN_WAIT cycles so a level left over from the last op is ignored
    assign done = is_multi(fpu_funct_q) ? (cnt_q >= CW'(MIN_WAIT) && fpu_finish)
                                        : (cnt_q == CW'(MIN_WAIT));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fpu_funct_d = fpu_funct_q;
        fpu_a_d     = fpu_a_q;
        fpu_b_d     = fpu_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        if (state_q == IDLE) begin
            if (req_valid) begin
                fpu_funct_d = req_funct;
                fpu_a_d     = req_a;
                fpu_b_d     = req_b;
                cnt_d       = '0;
                if (is_supported(req_funct)) begin
                    state_d = WAIT;
                end else begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                end
            end
        end else if (state_q == WAIT) begin
`ifdef FPU_TIMEOUT_EN
            cnt_d = cnt_q + 1'b1;
`else
            cnt_d = (cnt_q == CW'(MIN_WAIT)) ? cnt_q : cnt_q + 1'b1;
`endif
            if (done) begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = fpu_o;
                rsp_err_d   = 1'b0;
            end
`ifdef FPU_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT - 1)) begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = 32'h7FC0_0000;
                rsp_err_d   = 1'b1;
            end
`endif
        end else if (rsp_ready) begin
            state_d     = IDLE;
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            fpu_funct_q <= '0;
            fpu_a_q     <= '0;
            fpu_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fpu_funct_q <= fpu_funct_d;
            fpu_a_q     <= fpu_a_d;
            fpu_b_q     <= fpu_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign fpu_funct = fpu_funct_q;
    assign fpu_a     = fpu_a_q;
    assign fpu_b     = fpu_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed scoreboard bench for fpu_issue_ctrl (MIN_WAIT=2, TIMEOUT=64).
module tb_fpu_issue_ctrl;
    logic        clk = 1'b0, reset = 1'b1, req_valid = 1'b0, rsp_ready = 1'b0, fpu_finish = 1'b0;
    logic [3:0]  req_funct = 4'd0;
    logic [31:0] req_a = '0, req_b = '0, fpu_o = '0;
    logic        req_ready, rsp_valid, rsp_err, busy;
    logic [3:0]  fpu_funct;
    logic [31:0] fpu_a, fpu_b, rsp_data;
    int          compared = 0, mismatched = 0;

    typedef struct {logic [31:0] data; logic err; int lat;} exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    fpu_issue_ctrl #(.MIN_WAIT(2), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct(req_funct),
        .req_a(req_a), .req_b(req_b),
        .fpu_funct(fpu_funct), .fpu_a(fpu_a), .fpu_b(fpu_b),
        .fpu_o(fpu_o), .fpu_finish(fpu_finish),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge in IDLE; finishes at the negedge after the response handshake.
    task automatic do_op(input string tag, input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] fo, input int fin_k, input bit stale, input int hold,
                         input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
        exp_t        e;
        int          bad = 0;
        bit          got = 1'b0;
        logic [31:0] held;
        req_valid  = 1'b1;
        req_funct  = f;
        req_a      = a;
        req_b      = b;
        fpu_finish = stale;
        fpu_o      = stale ? 32'hDEAD_BEEF : fo;
        check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        sb.push_back('{exp_data, exp_err, exp_lat});
        @(posedge clk);
        for (int c = 1; c <= 300 && !got; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            req_a     = ~a;
            req_b     = ~b;
            req_funct = ~f;
            if (fpu_a !== a || fpu_b !== b || fpu_funct !== f) bad++;
            if (rsp_valid === 1'b1) begin
                got = 1'b1;
                e = sb.pop_front();
                check({tag, ".latency"}, 32'(c), 32'(e.lat));
                check({tag, ".rsp_data"}, rsp_data, e.data);
                check({tag, ".rsp_err"}, 32'(rsp_err), 32'(e.err));
            end else begin
                fpu_finish = (c - 1 == fin_k) || (stale && c - 1 < 2);
                fpu_o      = (stale && c - 1 < 2) ? 32'hDEAD_BEEF : fo;
            end
        end
        check({tag, ".rsp_seen"}, 32'(got), 32'd1);
        if (!got) void'(sb.pop_front());
        held = rsp_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== held || req_ready !== 1'b0 || busy !== 1'b1) bad++;
        end
        check({tag, ".hold_bad"}, 32'(bad), 32'd0);
        rsp_ready  = 1'b1;
        fpu_finish = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, ".rsp_valid_drop"}, 32'(rsp_valid), 32'd0);
        check({tag, ".busy_idle"}, 32'(busy), 32'd0);
        check({tag, ".fpu_a_kept"}, fpu_a, a);
    endtask

    initial begin
        int bad;
        req_valid = 1'b1;
        req_funct = 4'd0;
        req_a     = 32'h3F80_0000;
        req_b     = 32'h4000_0000;
        repeat (3) @(negedge clk);
        check("rst.fpu_funct", 32'(fpu_funct), 32'd0);
        check("rst.fpu_a", fpu_a, 32'd0);
        check("rst.fpu_b", fpu_b, 32'd0);
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.rsp_data", rsp_data, 32'd0);
        check("rst.rsp_err", 32'(rsp_err), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.req_ready", 32'(req_ready), 32'd1);
        reset = 1'b0;
        do_op("add", 4'd0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 5, 1'b0, 10, 32'h4040_0000, 1'b0, 7);
        do_op("stale", 4'd1, 32'h40A0_0000, 32'h4000_0000, 32'h40E0_0000, 3, 1'b1, 0, 32'h40E0_0000, 1'b0, 5);
        do_op("comb5", 4'd5, 32'h3F80_0000, 32'h0000_0000, 32'hBF80_0000, -1, 1'b0, 0, 32'hBF80_0000, 1'b0, 4);
        do_op("comb4", 4'd4, 32'h4120_0000, 32'h0000_0001, 32'h4120_0000, -1, 1'b1, 0, 32'h4120_0000, 1'b0, 4);
        do_op("unsup2", 4'd2, 32'h1111_1111, 32'h2222_2222, 32'h1234_5678, -1, 1'b0, 3, 32'h0000_0000, 1'b1, 1);
        do_op("unsup15", 4'd15, 32'h3333_3333, 32'h4444_4444, 32'h1234_5678, 0, 1'b0, 0, 32'h0000_0000, 1'b1, 1);
        do_op("minlat", 4'd3, 32'h4040_0000, 32'h4080_0000, 32'h4140_0000, 2, 1'b0, 0, 32'h4140_0000, 1'b0, 4);
`ifdef FPU_TIMEOUT_EN
        do_op("timeout", 4'd3, 32'h3F80_0000, 32'h3F80_0000, 32'h5555_5555, -1, 1'b0, 0, 32'h7FC0_0000, 1'b1, 65);
        do_op("finish_wins", 4'd0, 32'h3F00_0000, 32'h3F00_0000, 32'h3F80_0000, 63, 1'b0, 0, 32'h3F80_0000, 1'b0, 65);
`endif
        req_valid  = 1'b1;
        req_funct  = 4'd3;
        req_a      = 32'h4100_0000;
        req_b      = 32'h4200_0000;
        fpu_finish = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        bad = 0;
`ifdef FPU_TIMEOUT_EN
        repeat (20) begin
`else
        repeat (200) begin
`endif
            @(negedge clk);
            if (busy !== 1'b1 || rsp_valid !== 1'b0) bad++;
        end
        check("hang.busy_bad", 32'(bad), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.req_ready", 32'(req_ready), 32'd1);
        check("midrst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst.fpu_a", fpu_a, 32'd0);
        reset = 1'b0;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) bad++;
        end
        check("midrst.no_rsp", 32'(bad), 32'd0);
        check("sb.empty", 32'(sb.size()), 32'd0);
        do_op("recover", 4'd4, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, -1, 1'b0, 0, 32'h4080_0000, 1'b0, 4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Issue controller sitting between the CPU datapath and the `fpu` block. It accepts one floating-point request at a time over a valid/ready handshake, holds the `fpu` operands and function code stable, and waits for the `fpu` finish flag. It then returns the result over a valid/ready response channel and drives `busy` so the core can stall.

## Interface

Parameters:
- `MIN_WAIT`, 2: number of WAIT cycles during which `fpu_finish` is ignored (masks a stale finish from the previous op); must be ≥1.
- `TIMEOUT`, 64: WAIT cycles before a multi-cycle op is abandoned; must be > `MIN_WAIT`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request.
- `req_funct` in 4: fpu function code.
- `req_a`, `req_b` in 32: IEEE-754 single operands.
- `fpu_funct` out 4: registered function code to `fpu`.
- `fpu_a`, `fpu_b` out 32: registered operands to `fpu`.
- `fpu_o` in 32: `fpu` result.
- `fpu_finish` in 1: `fpu` finish flag, level.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts response.
- `rsp_data` out 32: result.
- `rsp_err` out 1: unsupported funct or timeout.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation

- States: IDLE, WAIT, RESP. Reset → IDLE.
- Reset values: `fpu_funct`=0, `fpu_a`=`fpu_b`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `busy`=0, wait counter `cnt`=0. `req_ready`=1, because it is decoded as state==IDLE.
- Funct classes:
  - 0, 1, 3: multi-cycle; complete on qualified finish.
  - 4, 5: combinational; complete at `cnt`==`MIN_WAIT` with no finish needed.
  - 2 and 6–15: unsupported.
- IDLE: on `req_valid && req_ready`, register funct, a, b into `fpu_*`; clear `cnt`.
  - Supported funct → WAIT.
  - Unsupported funct → RESP with `rsp_data`=0, `rsp_err`=1.
- WAIT: `cnt` increments every cycle.
  - Qualified finish is `cnt ≥ MIN_WAIT && fpu_finish`. On a qualified finish (class 0/1/3), or at `cnt`==`MIN_WAIT` (class 4/5): capture `fpu_o` into `rsp_data`, set `rsp_err`=0 → RESP.
  - Timeout (`TIMEOUT_EN` only): at `cnt`==`TIMEOUT`−1 with no qualified finish, set `rsp_data`=32'h7FC00000 (qNaN), `rsp_err`=1 → RESP.
  - Finish and timeout in the same cycle: finish wins.
- RESP: `rsp_valid`=1, `rsp_data`/`rsp_err` held stable. On `rsp_ready` → IDLE, `rsp_valid` drops next cycle. `req_ready`=0 throughout.
- `fpu_*` outputs hold their values through WAIT and RESP and after return to IDLE, until the next accept.
- `fpu_finish` asserted in IDLE or RESP is ignored.
- Reset mid-operation: immediate return to IDLE with all reset values; the in-flight result is discarded.

## Timing

- Accept at edge N. `fpu_*` valid from cycle N+1, which is WAIT cycle k=0.
- Finish qualified in WAIT cycle k → `rsp_valid` high in cycle N+k+2.
  - Minimum for a multi-cycle op: k=`MIN_WAIT`, latency `MIN_WAIT`+2 cycles.
  - Combinational ops (4, 5): always latency `MIN_WAIT`+2.
- Unsupported funct: `rsp_valid` high in cycle N+1.
- Timeout: `rsp_valid` high in cycle N+`TIMEOUT`+1.
- Back-to-back issue: one IDLE cycle between the response handshake and the next accept. Throughput ≤ one op per (latency+1) cycles.
- All outputs are registered except `req_ready` and `busy`, which are decoded from state.

## Configuration

- `FPU_TIMEOUT_EN` defined: timeout watchdog as above; `cnt` counts to `TIMEOUT`−1.
- Not defined:
  - No timeout. WAIT holds indefinitely until a qualified finish.
  - `cnt` saturates at `MIN_WAIT`.
  - `rsp_err` asserts only for unsupported funct.
  - The `TIMEOUT` parameter is unused.

## Test plan

- Reset with `req_valid`=1 held → all outputs at reset values, `req_ready`=1. After release, the request is accepted on the first edge.
- funct=0, a=32'h3F800000, b=32'h40000000, model finish 5 cycles after issue with `fpu_o`=32'h40400000 → `rsp_valid` at N+7, `rsp_data`=32'h40400000, `rsp_err`=0. `fpu_a`/`fpu_b` stable throughout.
- Stale finish held high from the previous op into WAIT cycles 0–1, real result at k=3 → capture at k=3, not k=0.
- funct=5, a=32'h3F800000, `fpu_o`=32'hBF800000 with `fpu_finish`=0 → `rsp_data`=32'hBF800000 at N+4. funct=2 → `rsp_err`=1, `rsp_data`=0 at N+1.
- With `FPU_TIMEOUT_EN`, funct=3, finish never asserted → `rsp_data`=32'h7FC00000, `rsp_err`=1 at N+65. Without the macro → `busy` stays 1 for 200 cycles.
- `rsp_ready` held low 10 cycles → `rsp_valid`/`rsp_data` stable, `req_ready`=0. Assert `reset` during WAIT → IDLE next cycle, no response emitted.
